// File: rtl/la_cdc_txctrl.sv
// Source-side sequencer for a toggle req/ack multi-bit CDC: captures one word,
// holds it on tx_data, toggles tx_req and waits for the synchronized ack echo.

module la_dsync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_r;

    // Plain flop chain; deliberately unreset so it stays a clean synchronizer.
    always_ff @(posedge clk) begin
        sync_r <= {sync_r[STAGES-2:0], d};
    end

    assign q = sync_r[STAGES-1];
endmodule

module la_cdc_txctrl #(
    parameter int DW      = 8,
    parameter int STAGES  = 2,
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] tx_data,
    output logic          tx_req,
    input  logic          ack_async,
    output logic          busy,
    output logic          err,
    input  logic          err_clear
);
    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [DW-1:0] tx_data_r;
    logic          tx_req_r;
    logic          err_r;
    logic          ack_sync_s;
    logic [CW-1:0] cnt_inc_s;
    logic          waiting_s;
    logic          hit_s;
    logic          match_s;

    la_dsync #(.STAGES(STAGES)) u_ack_sync (
        .clk (clk),
        .d   (ack_async),
        .q   (ack_sync_s)
    );

    // Saturating counter increment and timeout detection for WAIT/SYNC.
    always_comb begin
        if (cnt_r == TO_C) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CW'(1);
        end
        waiting_s = (state_r == ST_WAIT) || (state_r == ST_SYNC);
        hit_s     = waiting_s && (TIMEOUT != 0) && (cnt_inc_s == TO_C);
        match_s   = (ack_sync_s == tx_req_r);
    end

    // Handshake FSM with registered data, request, counter and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_SYNC;
            cnt_r     <= {CW{1'b0}};
            tx_data_r <= {DW{1'b0}};
            tx_req_r  <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_SYNC: begin
                    cnt_r <= cnt_inc_s;
                    if (match_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_SYNC;
                    end
                end
                ST_IDLE: begin
                    if (in_valid) begin
                        tx_data_r <= in_data;
                        tx_req_r  <= ~tx_req_r;
                        cnt_r     <= {CW{1'b0}};
                        state_r   <= ST_WAIT;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_inc_s;
                    if (match_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    cnt_r   <= {CW{1'b0}};
                    state_r <= ST_SYNC;
                end
            endcase

            // A timeout in the same cycle as err_clear keeps the flag set.
            if (hit_s) begin
                err_r <= 1'b1;
            end else if (err_clear) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign in_ready = (state_r == ST_IDLE);
    assign busy     = (state_r != ST_IDLE);
    assign tx_data  = tx_data_r;
    assign tx_req   = tx_req_r;
    assign err      = err_r;
endmodule

// File: tb/tb_la_cdc_txctrl.sv
// Directed self-checking bench for la_cdc_txctrl (STAGES=2, TIMEOUT=10).
module tb_la_cdc_txctrl;
    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       ack_async;
    logic       busy;
    logic       err;
    logic       err_clear;

    int n_cmp = 0;
    int n_bad = 0;

    la_cdc_txctrl #(.DW(8), .STAGES(2), .TIMEOUT(10), .CW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .ack_async (ack_async),
        .busy      (busy),
        .err       (err),
        .err_clear (err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int lim, output int cyc);
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < lim) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        int         na;
        int         acc_t [3];
        logic [7:0] dat [3];
        logic       req [3];
        logic       prev;
        logic       stable;
        logic [7:0] words [6];
        int         dly [6];

        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        dly   = '{0, 1, 2, 5, 3, 7};
        acc_t = '{0, 0, 0};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; ack_async = 1'b0; err_clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_tx_req", tx_req, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        #1;
        chk("sync_in_ready", in_ready, 0);
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);

        // Single word, echo one cycle after tx_req toggles.
        in_valid = 1'b1; in_data = 8'hA5;
        @(negedge clk);
        in_valid = 1'b0;
        chk("a_tx_req", tx_req, 1);
        chk("a_tx_data", tx_data, 8'hA5);
        chk("a_in_ready", in_ready, 0);
        chk("a_busy", busy, 1);
        @(negedge clk);
        ack_async = 1'b1;
        wait_ready(20, cyc);
        chk("a_ready_lat", cyc + 1, 4);
        chk("a_tx_data_held", tx_data, 8'hA5);

        // Back-to-back words with immediate echo.
        prev = tx_req; na = 0;
        in_valid = 1'b1; in_data = 8'h01;
        for (int t = 0; t < 40 && na < 3; t++) begin
            @(negedge clk);
            if (tx_req !== prev) begin
                acc_t[na] = t; dat[na] = tx_data; req[na] = tx_req;
                prev = tx_req;
                na++;
                in_data = (na == 1) ? 8'h02 : 8'h03;
                if (na == 3) in_valid = 1'b0;
            end
            ack_async = tx_req;
        end
        chk("b_count", na, 3);
        chk("b_req0", req[0], 0);
        chk("b_req1", req[1], 1);
        chk("b_req2", req[2], 0);
        chk("b_dat0", dat[0], 8'h01);
        chk("b_dat1", dat[1], 8'h02);
        chk("b_dat2", dat[2], 8'h03);
        chk("b_gap01", acc_t[1] - acc_t[0], 4);
        chk("b_gap12", acc_t[2] - acc_t[1], 4);
        wait_ready(20, cyc);
        chk("b_drain", in_ready, 1);

        // Timeout with no ack, then late ack and clear.
        in_valid = 1'b1; in_data = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("c_err_before", err, 0);
        @(negedge clk);
        chk("c_err_at_to", err, 1);
        chk("c_busy_at_to", busy, 1);
        repeat (3) @(negedge clk);
        chk("c_busy_hold", busy, 1);
        chk("c_data_hold", tx_data, 8'h3C);
        ack_async = 1'b1;
        wait_ready(20, cyc);
        chk("c_late_ack_lat", cyc, 3);
        chk("c_err_sticky", err, 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("c_err_cleared", err, 0);

        // Timeout while err_clear is held: set wins.
        err_clear = 1'b1;
        in_valid = 1'b1; in_data = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        chk("d_tx_req", tx_req, 0);
        repeat (9) @(negedge clk);
        chk("d_err_before", err, 0);
        @(negedge clk);
        chk("d_err_set_wins", err, 1);
        @(negedge clk);
        chk("d_err_hold", err, 1);
        err_clear = 1'b0;

        // Reset mid-WAIT with ack stuck high.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("e_tx_req", tx_req, 0);
        chk("e_tx_data", tx_data, 0);
        chk("e_err", err, 0);
        chk("e_in_ready", in_ready, 0);
        repeat (9) @(negedge clk);
        chk("e_err_before", err, 0);
        chk("e_sync_held", in_ready, 0);
        @(negedge clk);
        chk("e_err_at_to", err, 1);
        chk("e_busy", busy, 1);
        ack_async = 1'b0;
        wait_ready(20, cyc);
        chk("e_sync_exit_lat", cyc, 3);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;

        // Stray ack toggle in IDLE, then an accept that completes at once.
        ack_async = 1'b1;
        repeat (4) @(negedge clk);
        chk("f_idle_stays", in_ready, 1);
        chk("f_req_unchanged", tx_req, 0);
        in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk);
        in_valid = 1'b0;
        chk("f_accept_req", tx_req, 1);
        chk("f_accept_busy", in_ready, 0);
        @(negedge clk);
        chk("f_fast_done", in_ready, 1);
        chk("f_data", tx_data, 8'h77);

        // Varied ack delays: data held and in order.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = words[i];
            @(negedge clk);
            in_valid = 1'b0;
            chk("g_data", tx_data, words[i]);
            stable = 1'b1;
            for (int k = 0; k < dly[i]; k++) begin
                @(negedge clk);
                if (tx_data !== words[i] || in_ready !== 1'b0) stable = 1'b0;
            end
            ack_async = ~ack_async;
            wait_ready(30, cyc);
            if (tx_data !== words[i]) stable = 1'b0;
            chk("g_stable", stable, 1);
            chk("g_ack_lat", cyc, 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
